rfphoenix_gpr_wb_arb: RTL and testbench

// - Shares the single GPR write port (wr/wthread/wa/i) among NREQ writeback sources (ALUs, FPU, load unit).
// - Each source pushes results via valid/ready into a private 2-entry FIFO.
// - A round-robin arbiter grants one FIFO head per cycle and drives the registered write port of the GP register file.
// - Also emits a writeback strobe so the scoreboard can clear pending-register bits.

---
 rtl/rfphoenix_gpr_wb_arb_pkg.sv | 28 ++
 rtl/rfphoenix_wb_fifo2.sv | 54 +++++
 rtl/rfphoenix_gpr_wb_arb.sv | 134 +++++++++++++
 tb/tb_rfphoenix_gpr_wb_arb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rfphoenix_gpr_wb_arb_pkg.sv
// Shared types for the GPR writeback arbiter: thread/register/value types and
// the queued writeback request payload.
package rfphoenix_gpr_wb_arb_pkg;

  localparam int unsigned NWBREQ = 4;
  localparam int unsigned TID_W  = 3;
  localparam int unsigned REG_W  = 6;
  localparam int unsigned VAL_W  = 32;

  typedef logic [TID_W-1:0] Tid;
  typedef struct packed {
    logic [REG_W-1:0] num;
  } Regspec;
  typedef logic [VAL_W-1:0] Value;

  typedef struct packed {
    Tid         tid;
    Regspec     wa;
    logic [3:0] wr;
    Value       val;
  } WbReq;

  // r0 targets and empty lane masks still clear the scoreboard but never write
  function automatic logic is_null_wr(WbReq r);
    return (r.wa.num == '0) || (r.wr == 4'b0000);
  endfunction

endpackage

// File: rtl/rfphoenix_wb_fifo2.sv
// Two-entry FIFO of writeback requests; 1-bit read/write pointers plus occupancy.
module rfphoenix_wb_fifo2
  import rfphoenix_gpr_wb_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  WbReq din,
  output WbReq dout,
  output logic empty,
  output logic full
);

  logic [1:0] cnt_q, cnt_d;
  logic       wp_q, wp_d;
  logic       rp_q, rp_d;
  WbReq       mem_q [2];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) wp_d = ~wp_q;
    if (pop)  rp_d = ~rp_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 2'd0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end

  assign dout  = mem_q[rp_q];
  assign empty = (cnt_q == 2'd0);
  assign full  = cnt_q[1];

endmodule

// File: rtl/rfphoenix_gpr_wb_arb.sv
// Round-robin arbiter sharing the single GPR write port among NREQ writeback
// sources, each buffered by a private 2-entry FIFO.
module rfphoenix_gpr_wb_arb
  import rfphoenix_gpr_wb_arb_pkg::*;
#(
  parameter int unsigned NREQ = NWBREQ
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  Tid     [NREQ-1:0]        req_tid,
  input  Regspec [NREQ-1:0]        req_wa,
  input  logic   [NREQ-1:0][3:0]   req_wr,
  input  Value   [NREQ-1:0]        req_val,
  input  logic                     wb_hold,
  output logic [3:0]               wr,
  output Tid                       wthread,
  output Regspec                   wa,
  output Value                     i,
  output logic                     wb_valid,
  output logic [$clog2(NREQ)-1:0]  wb_src
);

  localparam int unsigned SRC_W = $clog2(NREQ);

  WbReq              head  [NREQ];
  logic [NREQ-1:0]   empty;
  logic [NREQ-1:0]   full;
  logic [NREQ-1:0]   push;
  logic [NREQ-1:0]   pop;
  logic              rdy_en_q;

  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [3:0]        wr_q, wr_d;
  Tid                wthread_q, wthread_d;
  Regspec            wa_q, wa_d;
  Value              i_q, i_d;
  logic              wb_valid_q, wb_valid_d;
  logic [SRC_W-1:0]  wb_src_q, wb_src_d;

  logic              found;
  logic              gnt;
  logic [SRC_W-1:0]  win;
  logic [SRC_W-1:0]  idx;

  // Readiness comes from registered occupancy only and stays low during reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_en_q <= 1'b0;
    else      rdy_en_q <= 1'b1;
  end

  assign req_ready = {NREQ{rdy_en_q}} & ~full;
  assign push      = req_valid & req_ready;

  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    WbReq din;
    assign din = '{tid: req_tid[g], wa: req_wa[g], wr: req_wr[g], val: req_val[g]};

    rfphoenix_wb_fifo2 u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (din),
      .dout  (head[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  // Selection: first non-empty FIFO after the last winner, then next-state
  always_comb begin
    found      = 1'b0;
    win        = '0;
    idx        = '0;
    ptr_d      = ptr_q;
    wr_d       = 4'b0000;
    wb_valid_d = 1'b0;
    wthread_d  = wthread_q;
    wa_d       = wa_q;
    i_d        = i_q;
    wb_src_d   = wb_src_q;

    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = SRC_W'((32'(ptr_q) + k) % NREQ);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    gnt = found & ~wb_hold;
    pop = gnt ? (NREQ'(1) << win) : '0;

    if (gnt) begin
      ptr_d      = win;
      wb_valid_d = 1'b1;
      wb_src_d   = win;
      wthread_d  = head[win].tid;
      wa_d       = head[win].wa;
      i_d        = head[win].val;
      wr_d       = is_null_wr(head[win]) ? 4'b0000 : head[win].wr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= SRC_W'(NREQ - 1);
      wr_q       <= 4'b0000;
      wthread_q  <= '0;
      wa_q       <= '0;
      i_q        <= '0;
      wb_valid_q <= 1'b0;
      wb_src_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_q       <= wr_d;
      wthread_q  <= wthread_d;
      wa_q       <= wa_d;
      i_q        <= i_d;
      wb_valid_q <= wb_valid_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign wr       = wr_q;
  assign wthread  = wthread_q;
  assign wa       = wa_q;
  assign i        = i_q;
  assign wb_valid = wb_valid_q;
  assign wb_src   = wb_src_q;

endmodule

// File: tb/tb_rfphoenix_gpr_wb_arb.sv
// Directed bench for the GPR writeback arbiter: reset, latency, null writes,
// round-robin order, hold, reset mid-flight and FIFO backpressure.
module tb_rfphoenix_gpr_wb_arb;
  import rfphoenix_gpr_wb_arb_pkg::*;

  localparam int unsigned NREQ = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  Tid     [NREQ-1:0]      req_tid;
  Regspec [NREQ-1:0]      req_wa;
  logic   [NREQ-1:0][3:0] req_wr;
  Value   [NREQ-1:0]      req_val;
  logic                   wb_hold;
  logic [3:0]             wr;
  Tid                     wthread;
  Regspec                 wa;
  Value                   i;
  logic                   wb_valid;
  logic [1:0]             wb_src;

  int n_checks = 0;
  int n_errors = 0;

  rfphoenix_gpr_wb_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tid   (req_tid),
    .req_wa    (req_wa),
    .req_wr    (req_wr),
    .req_val   (req_val),
    .wb_hold   (wb_hold),
    .wr        (wr),
    .wthread   (wthread),
    .wa        (wa),
    .i         (i),
    .wb_valid  (wb_valid),
    .wb_src    (wb_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input logic [2:0] t, input logic [5:0] r,
                         input logic [3:0] w, input logic [31:0] v);
    req_tid[n]    = t;
    req_wa[n].num = r;
    req_wr[n]     = w;
    req_val[n]    = v;
  endtask

  logic [3:0]  seen_low;
  logic [31:0] got_q [$];
  logic        acc;

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_tid   = '0;
    req_wa    = '0;
    req_wr    = '0;
    req_val   = '0;
    wb_hold   = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_wr",       64'(wr), 64'(0));
    check("rst_wthread",  64'(wthread), 64'(0));
    check("rst_wa",       64'(wa.num), 64'(0));
    check("rst_i",        64'(i), 64'(0));
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_wb_src",   64'(wb_src), 64'(0));
    check("rst_ready",    64'(req_ready), 64'(0));
    rst = 1'b1;
    check("ready_at_release", 64'(req_ready), 64'(0));
    tick();
    check("ready_after_release", 64'(req_ready), 64'hF);

    // Single write from requester 2: visible two edges after acceptance
    set_req(2, 3'd1, 6'd5, 4'hF, 32'h1234);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    check("single_not_yet", 64'(wb_valid), 64'(0));
    tick();
    check("single_wr",       64'(wr), 64'hF);
    check("single_wthread",  64'(wthread), 64'(1));
    check("single_wa",       64'(wa.num), 64'(5));
    check("single_i",        64'(i), 64'h1234);
    check("single_wb_valid", 64'(wb_valid), 64'(1));
    check("single_wb_src",   64'(wb_src), 64'(2));
    tick();
    check("single_one_cycle", 64'(wb_valid), 64'(0));
    check("single_wr_clear",  64'(wr), 64'(0));
    check("single_i_hold",    64'(i), 64'h1234);

    // Null writes: r0 target, and empty lane mask
    set_req(0, 3'd2, 6'd0, 4'hF, 32'hDEAD);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    check("null_r0_valid", 64'(wb_valid), 64'(1));
    check("null_r0_wr",    64'(wr), 64'(0));
    check("null_r0_src",   64'(wb_src), 64'(0));
    set_req(3, 3'd3, 6'd7, 4'h0, 32'hBEEF);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    check("null_mask_valid", 64'(wb_valid), 64'(1));
    check("null_mask_wr",    64'(wr), 64'(0));
    check("null_mask_src",   64'(wb_src), 64'(3));
    check("null_mask_i",     64'(i), 64'hBEEF);

    // Round-robin with all requesters continuously valid (pointer now 3)
    for (int n = 0; n < 4; n++) set_req(n, 3'(n), 6'(n + 8), 4'hF, 32'h100 * n);
    req_valid = 4'hF;
    seen_low  = '0;
    tick();
    check("rr_first_empty", 64'(wb_valid), 64'(0));
    for (int g = 0; g < 8; g++) begin
      seen_low |= ~req_ready;
      tick();
      check("rr_valid", 64'(wb_valid), 64'(1));
      check("rr_src",   64'(wb_src), 64'(g % 4));
      check("rr_i",     64'(i), 64'(32'h100 * (g % 4)));
    end
    check("rr_ready_toggled", 64'(seen_low), 64'hF);

    // Hold mid-stream: no grants, data held, then resume after pointer 3
    wb_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_valid", 64'(wb_valid), 64'(0));
      check("hold_wr",    64'(wr), 64'(0));
      check("hold_i",     64'(i), 64'h300);
    end
    check("hold_all_full", 64'(req_ready), 64'h0);
    wb_hold = 1'b0;
    tick();
    check("resume_src0", 64'(wb_src), 64'(0));
    check("resume_v0",   64'(wb_valid), 64'(1));
    tick();
    check("resume_src1", 64'(wb_src), 64'(1));

    // Reset with FIFOs loaded
    wb_hold = 1'b1;
    tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_wr",    64'(wr), 64'(0));
    check("midrst_i",     64'(i), 64'(0));
    check("midrst_wa",    64'(wa.num), 64'(0));
    check("midrst_valid", 64'(wb_valid), 64'(0));
    check("midrst_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    req_valid = '0;
    wb_hold   = 1'b0;
    rst       = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("postrst_empty", 64'(wb_valid), 64'(0));
    end
    check("postrst_ready", 64'(req_ready), 64'hF);

    // Backpressure on requester 1 with hold asserted
    wb_hold = 1'b1;
    set_req(1, 3'd4, 6'd9, 4'h3, 32'hA1);
    req_valid = 4'b0010;
    tick();
    check("bp_ready_after1", 64'(req_ready[1]), 64'(1));
    set_req(1, 3'd4, 6'd10, 4'h3, 32'hB2);
    tick();
    check("bp_ready_after2", 64'(req_ready[1]), 64'(0));
    set_req(1, 3'd4, 6'd11, 4'h3, 32'hC3);
    tick();
    check("bp_still_full", 64'(req_ready[1]), 64'(0));
    check("bp_no_grant",   64'(wb_valid), 64'(0));
    wb_hold = 1'b0;
    for (int c = 0; c < 12; c++) begin
      acc = req_valid[1] & req_ready[1];
      tick();
      if (acc) req_valid = '0;
      if (wb_valid) begin
        got_q.push_back(i);
        check("bp_src", 64'(wb_src), 64'(1));
        check("bp_wr",  64'(wr), 64'h3);
      end
    end
    check("bp_count", 64'(got_q.size()), 64'(3));
    if (got_q.size() == 3) begin
      check("bp_order0", 64'(got_q[0]), 64'hA1);
      check("bp_order1", 64'(got_q[1]), 64'hB2);
      check("bp_order2", 64'(got_q[2]), 64'hC3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
